sync_sram_ctl: RTL and testbench

- Clocked, parametrised successor to the team's 2k x 8 asynchronous SRAM model.
- Keeps the active-low chipEnable, writeEnable and outputEnable controls, now sampled on the clock.
- Adds configurable width and depth, a programmable read latency with a data_valid strobe, and a post-reset memory-clear state machine.
- Used as the on-chip scratch memory behind the lab bus controller.

---
 rtl/sync_sram_ctl.sv | 170 +++++++++++++++++
 tb/tb_sync_sram_ctl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_sram_ctl.sv
// Clocked single-port scratch SRAM: active-low CE/WE/OE sampled on clk, post-reset clear, READ_LAT 1 or 2.
// Define SYNC_SRAM_PARITY_EN to store an even-parity bit per word (parity_inject / parity_err ports).
module sync_sram_ctl #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 11,
    parameter int                READ_LAT  = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              chipEnable,
    input  logic              writeEnable,
    input  logic              outputEnable,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy
`ifdef SYNC_SRAM_PARITY_EN
    ,
    input  logic              parity_inject,
    output logic              parity_err
`endif
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_dat;
    logic                rd_req;

    logic                dv1_d, dv1_q;
    logic [DATA_W-1:0]   do1_d, do1_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_dat  = data_in;
        rd_req  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q[ADDR_W-1:0];
                wr_dat  = CLEAR_VAL;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                // Write wins over read when both enables are low.
                if (!chipEnable) begin
                    if (!writeEnable) begin
                        wr_en = 1'b1;
                    end else if (!outputEnable) begin
                        rd_req = 1'b1;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == S_CLEAR);

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Data is captured at the request edge, so a write on the next edge cannot disturb it.
    always_comb begin
        dv1_d = rd_req;
        do1_d = rd_req ? mem[addr] : {DATA_W{1'b1}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dv1_q <= 1'b0;
            do1_q <= {DATA_W{1'b1}};
        end else begin
            dv1_q <= dv1_d;
            do1_q <= do1_d;
        end
    end

`ifdef SYNC_SRAM_PARITY_EN
    logic par_mem [DEPTH];
    logic wr_par;
    logic pe1_d, pe1_q;

    always_comb begin
        wr_par = ^wr_dat;
        if (state_q == S_IDLE && parity_inject) begin
            wr_par = ~wr_par;
        end
        pe1_d = rd_req && ((^mem[addr]) != par_mem[addr]);
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            par_mem[wr_addr] <= wr_par;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe1_q <= 1'b0;
        end else begin
            pe1_q <= pe1_d;
        end
    end
`endif

    if (READ_LAT == 2) begin : g_lat2
        logic              dv2_q;
        logic [DATA_W-1:0] do2_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dv2_q <= 1'b0;
                do2_q <= {DATA_W{1'b1}};
            end else begin
                dv2_q <= dv1_q;
                do2_q <= do1_q;
            end
        end
        assign data_valid = dv2_q;
        assign data_out   = do2_q;
`ifdef SYNC_SRAM_PARITY_EN
        logic pe2_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pe2_q <= 1'b0;
            end else begin
                pe2_q <= pe1_q;
            end
        end
        assign parity_err = pe2_q;
`endif
    end else begin : g_lat1
        assign data_valid = dv1_q;
        assign data_out   = do1_q;
`ifdef SYNC_SRAM_PARITY_EN
        assign parity_err = pe1_q;
`endif
    end

endmodule

// File: tb/tb_sync_sram_ctl.sv
// Directed bench for sync_sram_ctl: a = 16 words/lat 1, b = 2048 words/lat 1, c = 16 words/lat 2.
module tb_sync_sram_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [10:0] addr = 11'h000;
    logic        ce = 1'b1;
    logic        we = 1'b1;
    logic        oe = 1'b1;
    logic        par_inj = 1'b0;

    logic [7:0]  dout_a, dout_b, dout_c;
    logic        dv_a, dv_b, dv_c;
    logic        busy_a, busy_b, busy_c;
    logic        pe_a, pe_b, pe_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_sram_ctl #(.DATA_W(8), .ADDR_W(4), .READ_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .data_in(data_in), .addr(addr[3:0]),
        .chipEnable(ce), .writeEnable(we), .outputEnable(oe),
        .data_out(dout_a), .data_valid(dv_a), .busy(busy_a)
`ifdef SYNC_SRAM_PARITY_EN
        , .parity_inject(par_inj), .parity_err(pe_a)
`endif
    );

    sync_sram_ctl #(.DATA_W(8), .ADDR_W(11), .READ_LAT(1)) dut_b (
        .clk(clk), .reset(reset), .data_in(data_in), .addr(addr),
        .chipEnable(ce), .writeEnable(we), .outputEnable(oe),
        .data_out(dout_b), .data_valid(dv_b), .busy(busy_b)
`ifdef SYNC_SRAM_PARITY_EN
        , .parity_inject(par_inj), .parity_err(pe_b)
`endif
    );

    sync_sram_ctl #(.DATA_W(8), .ADDR_W(4), .READ_LAT(2)) dut_c (
        .clk(clk), .reset(reset), .data_in(data_in), .addr(addr[3:0]),
        .chipEnable(ce), .writeEnable(we), .outputEnable(oe),
        .data_out(dout_c), .data_valid(dv_c), .busy(busy_c)
`ifdef SYNC_SRAM_PARITY_EN
        , .parity_inject(par_inj), .parity_err(pe_c)
`endif
    );

`ifndef SYNC_SRAM_PARITY_EN
    assign pe_a = 1'b0;
    assign pe_b = 1'b0;
    assign pe_c = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ce = 1'b1; we = 1'b1; oe = 1'b1;
    endtask

    task automatic drive_write(input logic [10:0] a, input logic [7:0] d);
        ce = 1'b0; we = 1'b0; oe = 1'b1; addr = a; data_in = d;
    endtask

    task automatic drive_read(input logic [10:0] a);
        ce = 1'b0; we = 1'b1; oe = 1'b0; addr = a;
    endtask

    // Edge count (after reset release) on which busy of dut_a / dut_c is first seen low.
    task automatic count_clear(output int na, output int nc);
        na = 0;
        nc = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (!busy_a && na == 0) na = i;
            if (!busy_c && nc == 0) nc = i;
            if (na != 0 && nc != 0) break;
        end
    endtask

    task automatic test_reset();
        int na, nc;
        drive_idle();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy_a !== 1'b1 || dv_a !== 1'b0 || dout_a !== 8'hFF) begin
            failures++;
            $display("FAIL reset_a: busy=%b dv=%b dout=%h exp busy=1 dv=0 dout=ff", busy_a, dv_a, dout_a);
        end
        checks++;
        if (busy_b !== 1'b1 || dv_b !== 1'b0 || dout_b !== 8'hFF) begin
            failures++;
            $display("FAIL reset_b: busy=%b dv=%b dout=%h exp busy=1 dv=0 dout=ff", busy_b, dv_b, dout_b);
        end
        step();
        step();
        checks++;
        if (busy_c !== 1'b1 || dv_c !== 1'b0 || dout_c !== 8'hFF) begin
            failures++;
            $display("FAIL reset_c: busy=%b dv=%b dout=%h exp busy=1 dv=0 dout=ff", busy_c, dv_c, dout_c);
        end
        // Held across the whole clear; must be dropped.
        drive_write(11'd5, 8'h77);
        reset = 1'b0;
        count_clear(na, nc);
        drive_idle();
        checks++;
        if (na != 16) begin
            failures++;
            $display("FAIL clear_len_a: busy fell at edge %0d exp 16", na);
        end
        checks++;
        if (nc != 16) begin
            failures++;
            $display("FAIL clear_len_c: busy fell at edge %0d exp 16", nc);
        end
    endtask

    task automatic test_clear_reads();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive_read(11'(i));
            else        drive_idle();
            step();
            checks++;
            if (i < 16) begin
                if (dv_a !== 1'b1 || dout_a !== 8'h00) begin
                    failures++;
                    $display("FAIL clear_read_a[%0d]: dv=%b dout=%h exp dv=1 dout=00", i, dv_a, dout_a);
                end
            end else if (dv_a !== 1'b0 || dout_a !== 8'hFF) begin
                failures++;
                $display("FAIL clear_read_a_end: dv=%b dout=%h exp dv=0 dout=ff", dv_a, dout_a);
            end
            checks++;
            if (i >= 1) begin
                if (dv_c !== 1'b1 || dout_c !== 8'h00) begin
                    failures++;
                    $display("FAIL clear_read_c[%0d]: dv=%b dout=%h exp dv=1 dout=00", i - 1, dv_c, dout_c);
                end
            end else if (dv_c !== 1'b0 || dout_c !== 8'hFF) begin
                failures++;
                $display("FAIL clear_read_c_lat: dv=%b dout=%h exp dv=0 dout=ff", dv_c, dout_c);
            end
        end
        step();
        checks++;
        if (dv_c !== 1'b0 || dout_c !== 8'hFF) begin
            failures++;
            $display("FAIL clear_read_c_end: dv=%b dout=%h exp dv=0 dout=ff", dv_c, dout_c);
        end
    endtask

    task automatic wait_b_idle();
        int left = 3000;
        while (busy_b === 1'b1 && left > 0) begin
            step();
            left--;
        end
        checks++;
        if (busy_b !== 1'b0) begin
            failures++;
            $display("FAIL clear_b_timeout: busy=%b exp 0 within 3000 cycles", busy_b);
        end
    endtask

    task automatic test_write_read();
        drive_write(11'h7FF, 8'hA5);
        step();
        checks++;
        if (dv_b !== 1'b0 || dout_b !== 8'hFF) begin
            failures++;
            $display("FAIL wr_cycle_b: dv=%b dout=%h exp dv=0 dout=ff", dv_b, dout_b);
        end
        drive_read(11'h7FF);
        step();
        checks++;
        if (dv_b !== 1'b1 || dout_b !== 8'hA5) begin
            failures++;
            $display("FAIL rd_7ff_b: dv=%b dout=%h exp dv=1 dout=a5", dv_b, dout_b);
        end
        drive_idle();
        step();
        checks++;
        if (dv_b !== 1'b0 || dout_b !== 8'hFF) begin
            failures++;
            $display("FAIL rd_7ff_strobe_b: dv=%b dout=%h exp dv=0 dout=ff", dv_b, dout_b);
        end
    endtask

    task automatic test_write_wins();
        ce = 1'b0; we = 1'b0; oe = 1'b0; addr = 11'd3; data_in = 8'h3C;
        step();
        checks++;
        if (dv_a !== 1'b0 || dv_b !== 1'b0) begin
            failures++;
            $display("FAIL write_wins_dv: dv_a=%b dv_b=%b exp 0 0", dv_a, dv_b);
        end
        drive_read(11'd3);
        step();
        checks++;
        if (dv_b !== 1'b1 || dout_b !== 8'h3C) begin
            failures++;
            $display("FAIL write_wins_rd_b: dv=%b dout=%h exp dv=1 dout=3c", dv_b, dout_b);
        end
        checks++;
        if (dv_a !== 1'b1 || dout_a !== 8'h3C) begin
            failures++;
            $display("FAIL write_wins_rd_a: dv=%b dout=%h exp dv=1 dout=3c", dv_a, dout_a);
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_c [5];
        logic       vld_c [5];
        logic [7:0] exp_a [5];
        logic       vld_a [5];
        exp_c = '{8'hFF, 8'h11, 8'h22, 8'h33, 8'hFF};
        vld_c = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_a = '{8'h11, 8'h22, 8'h33, 8'hFF, 8'hFF};
        vld_a = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        drive_write(11'd1, 8'h11); step();
        drive_write(11'd2, 8'h22); step();
        drive_write(11'd3, 8'h33); step();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive_read(11'(k + 1));
            else       drive_idle();
            step();
            checks++;
            if (dv_c !== vld_c[k] || dout_c !== exp_c[k]) begin
                failures++;
                $display("FAIL lat2_c[%0d]: dv=%b dout=%h exp dv=%b dout=%h", k, dv_c, dout_c, vld_c[k], exp_c[k]);
            end
            checks++;
            if (dv_a !== vld_a[k] || dout_a !== exp_a[k]) begin
                failures++;
                $display("FAIL lat1_a[%0d]: dv=%b dout=%h exp dv=%b dout=%h", k, dv_a, dout_a, vld_a[k], exp_a[k]);
            end
        end
    endtask

    task automatic test_read_then_write();
        drive_read(11'd2);
        step();
        drive_write(11'd2, 8'h99);
        step();
        checks++;
        if (dout_a !== 8'hFF || dv_a !== 1'b0) begin
            failures++;
            $display("FAIL rtw_wr_cycle_a: dv=%b dout=%h exp dv=0 dout=ff", dv_a, dout_a);
        end
        checks++;
        if (dv_c !== 1'b1 || dout_c !== 8'h22) begin
            failures++;
            $display("FAIL rtw_old_c: dv=%b dout=%h exp dv=1 dout=22", dv_c, dout_c);
        end
        drive_read(11'd2);
        step();
        checks++;
        if (dv_a !== 1'b1 || dout_a !== 8'h99) begin
            failures++;
            $display("FAIL rtw_new_a: dv=%b dout=%h exp dv=1 dout=99", dv_a, dout_a);
        end
        drive_idle();
        step();
    endtask

    task automatic test_old_data_a();
        drive_read(11'd4);
        step();
        checks++;
        if (dv_a !== 1'b1 || dout_a !== 8'h00) begin
            failures++;
            $display("FAIL rd4_a: dv=%b dout=%h exp dv=1 dout=00", dv_a, dout_a);
        end
        drive_write(11'd4, 8'h5A);
        step();
        drive_idle();
    endtask

`ifdef SYNC_SRAM_PARITY_EN
    task automatic test_parity();
        drive_write(11'd6, 8'h01);
        par_inj = 1'b1;
        step();
        par_inj = 1'b0;
        drive_read(11'd6);
        step();
        checks++;
        if (dv_a !== 1'b1 || pe_a !== 1'b1) begin
            failures++;
            $display("FAIL parity_inject: dv=%b perr=%b exp dv=1 perr=1", dv_a, pe_a);
        end
        drive_write(11'd6, 8'h01);
        step();
        drive_read(11'd6);
        step();
        checks++;
        if (dv_a !== 1'b1 || pe_a !== 1'b0) begin
            failures++;
            $display("FAIL parity_clean: dv=%b perr=%b exp dv=1 perr=0", dv_a, pe_a);
        end
        drive_idle();
        step();
        checks++;
        if (pe_a !== 1'b0 || pe_c !== 1'b0) begin
            failures++;
            $display("FAIL parity_idle: perr_a=%b perr_c=%b exp 0 0", pe_a, pe_c);
        end
    endtask
`endif

    task automatic test_reset_midread();
        int na, nc;
        int seen_dv = 0;
        drive_read(11'd1);
        step();
        drive_idle();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dv_c !== 1'b0 || dout_c !== 8'hFF || busy_c !== 1'b1) begin
            failures++;
            $display("FAIL midread_reset: dv=%b dout=%h busy=%b exp dv=0 dout=ff busy=1", dv_c, dout_c, busy_c);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (dv_c !== 1'b0) seen_dv++;
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            if (dv_c !== 1'b0) seen_dv++;
            step();
        end
        checks++;
        if (seen_dv != 0) begin
            failures++;
            $display("FAIL midread_no_dv: data_valid high %0d times exp 0", seen_dv);
        end
        count_clear(na, nc);
        checks++;
        if (nc != 14) begin
            failures++;
            $display("FAIL reclear_len_c: busy fell at edge %0d exp 14 (16 after release)", nc);
        end
        drive_read(11'd1);
        step();
        drive_idle();
        step();
        checks++;
        if (dv_c !== 1'b1 || dout_c !== 8'h00) begin
            failures++;
            $display("FAIL reclear_rd1_c: dv=%b dout=%h exp dv=1 dout=00", dv_c, dout_c);
        end
    endtask

    initial begin
        test_reset();
        test_clear_reads();
        wait_b_idle();
        test_write_read();
        test_write_wins();
        test_back_to_back();
        test_read_then_write();
        test_old_data_a();
`ifdef SYNC_SRAM_PARITY_EN
        test_parity();
`endif
        test_reset_midread();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
